// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B one bit per clock, LSB first,
// using a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sa_nxt;
    logic [WIDTH-1:0] sb, sb_nxt;
    logic [WIDTH-1:0] diff_q, diff_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             borrow, borrow_nxt;
    logic             a_msb, a_msb_nxt;
    logic             b_msb, b_msb_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             bor_q, bor_nxt;
    logic             ovf_q, ovf_nxt;
    logic             zero_q, zero_nxt;

    // Full-subtractor cell on the current LSBs
    logic bit_a, bit_b, bit_d, bit_br;
    assign bit_a  = sa[0];
    assign bit_b  = sb[0];
    assign bit_d  = bit_a ^ bit_b ^ borrow;
    assign bit_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            diff_q <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bor_q  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sa     <= sa_nxt;
            sb     <= sb_nxt;
            diff_q <= diff_nxt;
            cnt    <= cnt_nxt;
            borrow <= borrow_nxt;
            a_msb  <= a_msb_nxt;
            b_msb  <= b_msb_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            bor_q  <= bor_nxt;
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        sa_nxt     = sa;
        sb_nxt     = sb;
        diff_nxt   = diff_q;
        cnt_nxt    = cnt;
        borrow_nxt = borrow;
        a_msb_nxt  = a_msb;
        b_msb_nxt  = b_msb;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        bor_nxt    = bor_q;
        ovf_nxt    = ovf_q;
        zero_nxt   = zero_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    sa_nxt     = bus.a;
                    sb_nxt     = bus.b;
                    a_msb_nxt  = bus.a[WIDTH-1];
                    b_msb_nxt  = bus.b[WIDTH-1];
                    borrow_nxt = 1'b0;
                    cnt_nxt    = '0;
                    diff_nxt   = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                diff_nxt   = {bit_d, diff_q[WIDTH-1:1]};
                sa_nxt     = sa >> 1;
                sb_nxt     = sb >> 1;
                borrow_nxt = bit_br;
                cnt_nxt    = cnt + CNT_W'(1);
                // Flags are taken from the final bit so they line up with done
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    bor_nxt   = bit_br;
                    zero_nxt  = (diff_nxt == '0);
                    ovf_nxt   = (a_msb != b_msb) & (bit_d != a_msb);
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bor_q;
    assign bus.ovf        = ovf_q;
    assign bus.zero       = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus_if ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Done-pulse monitor: counts pulses and the cycle gap between them
    int cyc       = 0;
    int done_cnt  = 0;
    int last_done = 0;
    int done_gap  = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_if.done) begin
            done_cnt  <= done_cnt + 1;
            done_gap  <= cyc - last_done;
            last_done <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation with a start pulse; checks latency, result and hold
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
        int n;
        n = 0;
        @(negedge clk);
        bus_if.a     = av;
        bus_if.b     = bv;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_acc"}, 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a     = ~av;
        bus_if.b     = ~bv;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_if.done) break;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_diff"}, 32'(bus_if.diff), 32'(ed));
        check({tag, "_borrow"}, 32'(bus_if.borrow_out), 32'(eb));
        check({tag, "_ovf"}, 32'(bus_if.ovf), 32'(eo));
        check({tag, "_zero"}, 32'(bus_if.zero), 32'(ez));
        check({tag, "_busy_done"}, 32'(bus_if.busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
        check({tag, "_busy_idle"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_diff_hold"}, 32'(bus_if.diff), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int t;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_diff", 32'(bus_if.diff), 32'd0);
        check("rst_borrow", 32'(bus_if.borrow_out), 32'd0);
        check("rst_ovf", 32'(bus_if.ovf), 32'd0);
        check("rst_zero", 32'(bus_if.zero), 32'd0);
        rst_n = 1'b1;

        run_op("p35_12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0);
        run_op("p12_35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b0);
        run_op("p80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("p7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        run_op("p5a_5a", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);

        // Start held high: three back-to-back operations, 10 cycles apart
        @(negedge clk);
        bus_if.a     = 8'h5A;
        bus_if.b     = 8'h5A;
        bus_if.start = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (done_cnt < d0 + i + 1 && t < 40) begin
                @(negedge clk);
                t++;
            end
            check("b2b_wait", 32'(t < 40), 32'd1);
            if (i > 0) check("b2b_gap", 32'(done_gap), 32'd10);
            check("b2b_diff", 32'(bus_if.diff), 32'd0);
            check("b2b_zero", 32'(bus_if.zero), 32'd1);
            check("b2b_borrow", 32'(bus_if.borrow_out), 32'd0);
        end
        bus_if.start = 1'b0;
        repeat (25) @(negedge clk);
        check("b2b_count", 32'(done_cnt - d0), 32'd3);

        // Reset during RUN abandons the operation
        bus_if.a     = 8'h33;
        bus_if.b     = 8'h11;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        check("mid_rst_done", 32'(bus_if.done), 32'd0);
        check("mid_rst_diff", 32'(bus_if.diff), 32'd0);
        check("mid_rst_borrow", 32'(bus_if.borrow_out), 32'd0);
        check("mid_rst_ovf", 32'(bus_if.ovf), 32'd0);
        check("mid_rst_zero", 32'(bus_if.zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_idle", 32'(bus_if.busy), 32'd0);
        run_op("p00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Start pulses during RUN and during DONE are ignored
        @(negedge clk);
        bus_if.a     = 8'h10;
        bus_if.b     = 8'h01;
        bus_if.start = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.a     = 8'hFF;
        bus_if.b     = 8'hFF;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        t = 0;
        while (t < 30) begin
            @(posedge clk);
            #1;
            t++;
            if (bus_if.done) break;
        end
        check("ign_wait", 32'(t < 30), 32'd1);
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (15) @(negedge clk);
        check("ign_done_count", 32'(done_cnt - d0), 32'd1);
        check("ign_diff", 32'(bus_if.diff), 32'h0F);
        check("ign_busy", 32'(bus_if.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
